// File: rtl/rec_play_sequencer.sv
//------------------------------------------------------------------------------
// rec_play_sequencer : record/playback sequencer owning the sample-RAM port.
// Optional macro LOOP_PLAY_EN selects continuous looped playback.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rec_play_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_ADDR   = 1023
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  record_req,
  input  logic                  play_req,
  input  logic                  stop_req,
  input  logic                  sample_tick,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic                  play_valid,
  output logic                  recording,
  output logic                  playing,
  output logic [ADDR_WIDTH:0]   msg_len,
  output logic                  mem_full
);

`ifdef LOOP_PLAY_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(MAX_ADDR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH:0]   wr_ptr, wr_nx;
  logic [ADDR_WIDTH:0]   rd_ptr, rd_nx;
  logic [ADDR_WIDTH:0]   len_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic                  we_nx, re_nx, full_nx;
  // Blocks re-entering RECORD after a full stop until record_req drops.
  logic                  rec_lock, lock_nx;
  logic                  rec_go;

  assign rec_go    = record_req && !rec_lock;
  assign recording = (state == RECORD);
  assign playing   = (state == PLAY);

  always_comb begin
    state_nx = state;
    addr_nx  = mem_addr;
    we_nx    = 1'b0;
    re_nx    = 1'b0;
    wr_nx    = wr_ptr;
    rd_nx    = rd_ptr;
    len_nx   = msg_len;
    full_nx  = mem_full;
    lock_nx  = rec_lock && record_req;
    case (state)
      IDLE: begin
        addr_nx = '0;
        if (rec_go) begin
          state_nx = RECORD;
          wr_nx    = '0;
          len_nx   = '0;
          full_nx  = 1'b0;
        end else if (play_req && (msg_len != '0)) begin
          state_nx = PLAY;
          rd_nx    = '0;
        end
      end
      RECORD: begin
        if (mem_full) begin
          state_nx = IDLE;
          addr_nx  = '0;
          lock_nx  = record_req;
        end else if (!record_req || stop_req) begin
          state_nx = IDLE;
          addr_nx  = '0;
        end else if (sample_tick) begin
          we_nx   = 1'b1;
          addr_nx = wr_ptr[ADDR_WIDTH-1:0];
          wr_nx   = wr_ptr + 1'b1;
          len_nx  = msg_len + 1'b1;
          full_nx = (wr_ptr == LAST_ADDR);
        end
      end
      PLAY: begin
        if (rec_go || stop_req || (!LOOP && (rd_ptr == msg_len))) begin
          state_nx = IDLE;
          addr_nx  = '0;
        end else if (sample_tick) begin
          re_nx   = 1'b1;
          addr_nx = rd_ptr[ADDR_WIDTH-1:0];
          if (LOOP && (rd_ptr == msg_len - 1'b1)) begin
            rd_nx = '0;
          end else begin
            rd_nx = rd_ptr + 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        addr_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      play_valid <= 1'b0;
      msg_len    <= '0;
      mem_full   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rec_lock   <= 1'b0;
    end else begin
      state      <= state_nx;
      mem_addr   <= addr_nx;
      mem_we     <= we_nx;
      mem_re     <= re_nx;
      play_valid <= mem_re;
      msg_len    <= len_nx;
      mem_full   <= full_nx;
      wr_ptr     <= wr_nx;
      rd_ptr     <= rd_nx;
      rec_lock   <= lock_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rec_play_sequencer.sv
//------------------------------------------------------------------------------
// tb_rec_play_sequencer : directed self-checking bench for rec_play_sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rec_play_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        record_req = 1'b0;
  logic        play_req = 1'b0;
  logic        stop_req = 1'b0;
  logic        sample_tick = 1'b0;
  logic [9:0]  mem_addr;
  logic        mem_we, mem_re, play_valid, recording, playing, mem_full;
  logic [10:0] msg_len;

  int checks = 0;
  int failures = 0;

  rec_play_sequencer #(.ADDR_WIDTH(10), .MAX_ADDR(1023)) dut (
    .clk(clk), .reset_n(reset_n), .record_req(record_req), .play_req(play_req),
    .stop_req(stop_req), .sample_tick(sample_tick), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_re(mem_re), .play_valid(play_valid),
    .recording(recording), .playing(playing), .msg_len(msg_len), .mem_full(mem_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick_once();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic record_n(input int n);
    record_req = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      tick_once();
      @(negedge clk);
    end
    record_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int nwr;
    int bad;

    // Reset state
    #2;
    chk("rst_addr", mem_addr, 0);
    chk("rst_we_re_valid", {mem_we, mem_re, play_valid}, 0);
    chk("rst_rec_play", {recording, playing}, 0);
    chk("rst_len_full", {msg_len, mem_full}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Record 5 samples
    record_req = 1'b1;
    @(negedge clk);
    chk("rec_enter", recording, 1);
    for (int i = 0; i < 5; i++) begin
      tick_once();
      chk("rec_we", mem_we, 1);
      chk("rec_addr", mem_addr, i);
      chk("rec_len", msg_len, i + 1);
      @(negedge clk);
      chk("rec_we_pulse", mem_we, 0);
      chk("rec_addr_hold", mem_addr, i);
    end
    record_req = 1'b0;
    @(negedge clk);
    chk("rec_exit", recording, 0);
    chk("rec_exit_addr", mem_addr, 0);
    chk("rec_len5", msg_len, 5);
    chk("rec_not_full", mem_full, 0);

`ifndef LOOP_PLAY_EN
    // Single-shot playback of 5 samples, then an extra tick
    play_req = 1'b1;
    @(negedge clk);
    play_req = 1'b0;
    chk("play_enter", playing, 1);
    for (int i = 0; i < 5; i++) begin
      tick_once();
      chk("play_re", mem_re, 1);
      chk("play_addr", mem_addr, i);
      chk("play_we_low", mem_we, 0);
      @(negedge clk);
      chk("play_re_pulse", mem_re, 0);
      chk("play_valid", play_valid, 1);
      if (i < 4) chk("play_still", playing, 1);
    end
    chk("play_done", playing, 0);
    chk("play_done_addr", mem_addr, 0);
    tick_once();
    chk("play_6th_no_re", mem_re, 0);
    @(negedge clk);
    chk("play_6th_no_valid", play_valid, 0);
`else
    // Looped playback of a 3-sample message
    record_n(3);
    chk("loop_len3", msg_len, 3);
    play_req = 1'b1;
    @(negedge clk);
    play_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick_once();
      chk("loop_re", mem_re, 1);
      chk("loop_addr", mem_addr, i % 3);
      @(negedge clk);
      chk("loop_playing", playing, 1);
    end
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    chk("loop_stop", playing, 0);
    chk("loop_stop_addr", mem_addr, 0);
`endif

    // Fill memory: 1030 ticks, only 1024 writes
    record_req = 1'b1;
    @(negedge clk);
    nwr = 0;
    bad = 0;
    for (int i = 0; i < 1030; i++) begin
      tick_once();
      if (mem_we) begin
        if (mem_addr != nwr[9:0]) bad++;
        nwr++;
      end
      @(negedge clk);
      if (mem_we) bad++;
    end
    chk("full_writes", nwr, 1024);
    chk("full_addr_seq", bad, 0);
    chk("full_flag", mem_full, 1);
    chk("full_len", msg_len, 1024);
    chk("full_no_reentry", recording, 0);
    record_req = 1'b0;
    @(negedge clk);
    chk("full_persist", {msg_len, mem_full}, {11'd1024, 1'b1});

    // Record beats play when both requested
    record_n(5);
    chk("prio_len5", msg_len, 5);
    record_req = 1'b1;
    play_req = 1'b1;
    @(negedge clk);
    play_req = 1'b0;
    chk("prio_rec", {recording, playing}, 2'b10);
    chk("prio_len_clr", msg_len, 0);
    chk("prio_full_clr", mem_full, 0);
    record_req = 1'b0;
    @(negedge clk);
    play_req = 1'b1;
    @(negedge clk);
    play_req = 1'b0;
    chk("empty_play_ignored", playing, 0);
    tick_once();
    chk("empty_no_re", mem_re, 0);
    @(negedge clk);

    // Stop mid-play: pending valid for address 2 still completes
    record_n(5);
    play_req = 1'b1;
    @(negedge clk);
    play_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_once();
      if (i < 2) @(negedge clk);
    end
    chk("stop_read2", {mem_re, mem_addr}, {1'b1, 10'd2});
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    chk("stop_idle", playing, 0);
    chk("stop_addr0", mem_addr, 0);
    chk("stop_valid", play_valid, 1);
    @(negedge clk);

    // Asynchronous reset mid-record
    record_req = 1'b1;
    @(negedge clk);
    tick_once();
    chk("pre_rst_we", mem_we, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_we", mem_we, 0);
    chk("async_rst_rec", recording, 0);
    chk("async_rst_len", msg_len, 0);
    chk("async_rst_addr", mem_addr, 0);
    record_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
